// File: rtl/vm2002_pkg.sv
// vm2002_pkg
// Shared types for the parametrised vending-machine controller.
//   coins_t      : front-end coin code (NO_COINS/NICKEL/DIME/QUARTER)
//   status_t     : selection/restock status reported to the panel
//   state_idx_t  : bit position of each FSM state in the one-hot vector
//   state_t      : one-hot FSM state encoding
//   coin_value() : coin code -> credit in nickel units
package vm2002_pkg;

    typedef enum logic [1:0] {
        NO_COINS = 2'd0,
        NICKEL   = 2'd1,
        DIME     = 2'd2,
        QUARTER  = 2'd3
    } coins_t;

    typedef enum logic [1:0] {
        NO_STATUS    = 2'd0,
        AVAILABLE    = 2'd1,
        OUT_OF_STOCK = 2'd2,
        ERROR        = 2'd3
    } status_t;

    localparam int NUM_STATES = 6;

    typedef enum int unsigned {
        IDLE_IDX          = 0,
        RESTOCK_IDX       = 1,
        CHECK_ITEM_IDX    = 2,
        INSERT_COINS_IDX  = 3,
        DISPENSE_IDX      = 4,
        RETURN_CHANGE_IDX = 5
    } state_idx_t;

    typedef enum logic [NUM_STATES-1:0] {
        IDLE          = 6'b1 << IDLE_IDX,
        RESTOCK       = 6'b1 << RESTOCK_IDX,
        CHECK_ITEM    = 6'b1 << CHECK_ITEM_IDX,
        INSERT_COINS  = 6'b1 << INSERT_COINS_IDX,
        DISPENSE      = 6'b1 << DISPENSE_IDX,
        RETURN_CHANGE = 6'b1 << RETURN_CHANGE_IDX
    } state_t;

    // Credit value of a coin in nickel units; NO_COINS is worth nothing.
    function automatic logic [2:0] coin_value(input coins_t c);
        case (c)
            NICKEL:  return 3'd1;
            DIME:    return 3'd2;
            QUARTER: return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm_item_store.sv
// vm_item_store
// Per-slot stock counters and price table.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   rd_idx                : slot to read; rd_count/rd_price return 0 when out of range
//   dec_en, dec_idx       : decrement stock of one slot (never below 0)
//   add_en, add_idx,
//   add_qty               : add stock to one slot, saturating at MAX_COUNT
//   price_wr, price_idx,
//   price_val             : overwrite the price of one slot
// Writes to indices >= NUM_ITEMS are dropped.
module vm_item_store
    import vm2002_pkg::*;
#(
    parameter int NUM_ITEMS     = 7,
    parameter int SEL_W         = 3,
    parameter int COUNT_W       = 4,
    parameter int MAX_COUNT     = 8,
    parameter int AMOUNT_W      = 8,
    parameter int DEFAULT_PRICE = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SEL_W-1:0]    rd_idx,
    output logic [COUNT_W-1:0]  rd_count,
    output logic [AMOUNT_W-1:0] rd_price,
    input  logic                dec_en,
    input  logic [SEL_W-1:0]    dec_idx,
    input  logic                add_en,
    input  logic [SEL_W-1:0]    add_idx,
    input  logic [COUNT_W-1:0]  add_qty,
    input  logic                price_wr,
    input  logic [SEL_W-1:0]    price_idx,
    input  logic [AMOUNT_W-1:0] price_val
);

    localparam logic [SEL_W:0]      NUM_L = (SEL_W+1)'(NUM_ITEMS);
    localparam logic [COUNT_W-1:0]  MAX_L = COUNT_W'(MAX_COUNT);
    localparam logic [AMOUNT_W-1:0] DEF_L = AMOUNT_W'(DEFAULT_PRICE);

    logic [COUNT_W-1:0]  count_q [NUM_ITEMS];
    logic [AMOUNT_W-1:0] price_q [NUM_ITEMS];
    logic                rd_ok;

    // Widened sum so a large quantity cannot wrap past MAX_COUNT.
    function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] a,
                                                   input logic [COUNT_W-1:0] b);
        logic [COUNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, MAX_L}) ? MAX_L : s[COUNT_W-1:0];
    endfunction

    always_comb begin
        rd_ok    = ({1'b0, rd_idx} < NUM_L);
        rd_count = '0;
        rd_price = '0;
        if (rd_ok) begin
            rd_count = count_q[rd_idx];
            rd_price = price_q[rd_idx];
        end
    end

    // The loop only visits real slots, so out-of-range writes never match.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                count_q[i] <= MAX_L;
                price_q[i] <= DEF_L;
            end
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                if (add_en && add_idx == SEL_W'(i)) begin
                    count_q[i] <= sat_add(count_q[i], add_qty);
                end else if (dec_en && dec_idx == SEL_W'(i) && count_q[i] != '0) begin
                    count_q[i] <= count_q[i] - COUNT_W'(1);
                end
                if (price_wr && price_idx == SEL_W'(i)) begin
                    price_q[i] <= price_val;
                end
            end
        end
    end

endmodule

// File: rtl/vm_ctrl_param.sv
// vm_ctrl_param
// Vending-machine transaction controller with NUM_ITEMS slots, a writable
// price table, per-slot stock, change return, cancel/refund and a service
// (restock/reprice) mode.
// Optional build macro: VM_TIMEOUT_EN -- refunds idle credit after
// TIMEOUT_CYCLES cycles in INSERT_COINS without an accepted coin.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   coin_valid, coin            : coin strobe and coin code
//   sel_valid, sel              : selection strobe and slot index
//   cancel                      : user cancel (refund credit)
//   restock_mode                : service key
//   restock_valid, restock_item,
//   restock_qty                 : add stock to a slot while in service mode
//   price_wr, price_val         : reprice restock_item while in service mode
//   dispense_valid, dispense_item : one-cycle dispense pulse and slot
//   change_valid, change_amount : one-cycle change/refund pulse and value
//   coin_reject                 : one-cycle pulse, coin returned
//   status                      : last selection/restock status
//   amount                      : current credit in nickels
//   busy                        : FSM not in IDLE
// Strobe semantics: every *_valid / strobe input is a single-cycle request
// sampled on the rising clock edge; there is no ready/backpressure, so a
// strobe arriving in a state that does not consume it is dropped (coins are
// the exception: an unconsumed coin is answered with coin_reject). Every
// output pulse is registered and lasts exactly one cycle.
module vm_ctrl_param
    import vm2002_pkg::*;
#(
    parameter int NUM_ITEMS      = 7,
    parameter int SEL_W          = 3,
    parameter int COUNT_W        = 4,
    parameter int MAX_COUNT      = 8,
    parameter int AMOUNT_W       = 8,
    parameter int DEFAULT_PRICE  = 20,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  coins_t              coin,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    input  logic                restock_mode,
    input  logic                restock_valid,
    input  logic [SEL_W-1:0]    restock_item,
    input  logic [COUNT_W-1:0]  restock_qty,
    input  logic                price_wr,
    input  logic [AMOUNT_W-1:0] price_val,
    output logic                dispense_valid,
    output logic [SEL_W-1:0]    dispense_item,
    output logic                change_valid,
    output logic [AMOUNT_W-1:0] change_amount,
    output logic                coin_reject,
    output status_t             status,
    output logic [AMOUNT_W-1:0] amount,
    output logic                busy
);

    localparam logic [SEL_W:0] NUM_ITEMS_L = (SEL_W+1)'(NUM_ITEMS);

    state_t              state;
    logic [SEL_W-1:0]    sel_q;
    logic [AMOUNT_W-1:0] amount_q;
    logic [AMOUNT_W-1:0] refund_q;

    logic [AMOUNT_W-1:0] coin_units;
    logic [AMOUNT_W:0]   coin_sum;
    logic                coin_seen;
    logic                coin_overflow;
    logic                coin_accept;
    logic [AMOUNT_W-1:0] next_amount;
    logic                sel_ok;
    logic                restock_ok;
    logic                store_dec;
    logic                store_add;
    logic                store_price_wr;
    logic [COUNT_W-1:0]  item_count;
    logic [AMOUNT_W-1:0] item_price;
    logic                timed_out;

    // Coin accumulation is done one bit wider so a coin that would wrap the
    // credit register is detected and bounced instead of silently wrapping.
    always_comb begin
        coin_seen      = coin_valid && (coin != NO_COINS);
        coin_units     = AMOUNT_W'(coin_value(coin));
        coin_sum       = {1'b0, amount_q} + {1'b0, coin_units};
        coin_overflow  = coin_sum[AMOUNT_W];
        coin_accept    = (state == INSERT_COINS) && coin_seen && !coin_overflow;
        next_amount    = coin_accept ? coin_sum[AMOUNT_W-1:0] : amount_q;
        sel_ok         = ({1'b0, sel_q} < NUM_ITEMS_L);
        restock_ok     = ({1'b0, restock_item} < NUM_ITEMS_L);
        store_dec      = (state == DISPENSE);
        store_add      = (state == RESTOCK) && restock_valid && restock_ok;
        store_price_wr = (state == RESTOCK) && price_wr && restock_ok;
    end

    vm_item_store #(
        .NUM_ITEMS    (NUM_ITEMS),
        .SEL_W        (SEL_W),
        .COUNT_W      (COUNT_W),
        .MAX_COUNT    (MAX_COUNT),
        .AMOUNT_W     (AMOUNT_W),
        .DEFAULT_PRICE(DEFAULT_PRICE)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (sel_q),
        .rd_count (item_count),
        .rd_price (item_price),
        .dec_en   (store_dec),
        .dec_idx  (sel_q),
        .add_en   (store_add),
        .add_idx  (restock_item),
        .add_qty  (restock_qty),
        .price_wr (store_price_wr),
        .price_idx(restock_item),
        .price_val(price_val)
    );

`ifdef VM_TIMEOUT_EN
    localparam int               TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] idle_tmr_q;

    // Held at zero outside INSERT_COINS, which also makes it start from zero
    // on every entry; an accepted coin restarts the wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_tmr_q <= '0;
        end else if (state != INSERT_COINS || coin_accept) begin
            idle_tmr_q <= '0;
        end else if (idle_tmr_q != TMR_LIMIT) begin
            idle_tmr_q <= idle_tmr_q + TMR_W'(1);
        end
    end

    assign timed_out = (state == INSERT_COINS) && (idle_tmr_q == TMR_LIMIT);
`else
    assign timed_out = 1'b0;
`endif

    assign amount = amount_q;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sel_q          <= '0;
            amount_q       <= '0;
            refund_q       <= '0;
            status         <= NO_STATUS;
            dispense_valid <= 1'b0;
            dispense_item  <= '0;
            change_valid   <= 1'b0;
            change_amount  <= '0;
            coin_reject    <= 1'b0;
        end else begin
            dispense_valid <= 1'b0;
            dispense_item  <= '0;
            change_valid   <= 1'b0;
            change_amount  <= '0;
            // Any real coin not taken into credit is handed back.
            coin_reject    <= coin_seen && !coin_accept;

            case (state)
                IDLE: begin
                    if (restock_mode) begin
                        state <= RESTOCK;
                    end else if (sel_valid) begin
                        sel_q <= sel;
                        state <= CHECK_ITEM;
                    end
                end

                RESTOCK: begin
                    if ((restock_valid || price_wr) && !restock_ok) begin
                        status <= ERROR;
                    end
                    if (!restock_mode) begin
                        state <= IDLE;
                    end
                end

                CHECK_ITEM: begin
                    if (!sel_ok) begin
                        status <= ERROR;
                        state  <= IDLE;
                    end else if (item_count == '0) begin
                        status <= OUT_OF_STOCK;
                        state  <= IDLE;
                    end else begin
                        status <= AVAILABLE;
                        state  <= INSERT_COINS;
                    end
                end

                INSERT_COINS: begin
                    // A coin landing in the same cycle as a decision is still
                    // credited, so it shows up in the change or refund.
                    if (amount_q >= item_price) begin
                        amount_q <= next_amount;
                        state    <= DISPENSE;
                    end else if (cancel) begin
                        refund_q <= next_amount;
                        amount_q <= '0;
                        state    <= RETURN_CHANGE;
                    end else if (timed_out) begin
                        refund_q <= next_amount;
                        amount_q <= '0;
                        state    <= (next_amount != '0) ? RETURN_CHANGE : IDLE;
                    end else begin
                        amount_q <= next_amount;
                    end
                end

                DISPENSE: begin
                    dispense_valid <= 1'b1;
                    dispense_item  <= sel_q;
                    refund_q       <= amount_q - item_price;
                    amount_q       <= '0;
                    state          <= (amount_q != item_price) ? RETURN_CHANGE : IDLE;
                end

                RETURN_CHANGE: begin
                    change_valid  <= 1'b1;
                    change_amount <= refund_q;
                    state         <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
